// File: rtl/fib_bcd_display_if.sv
// Purpose: bundles the capture handshake and the display drive of the
//          Fibonacci BCD display stage into one interface.
// Signals:
//   value : 16-bit unsigned sample to convert
//   load  : capture request, sampled on the rising clock edge
//   bcd   : last completed result, five packed BCD digits
//   busy  : conversion in progress
//   done  : one-cycle pulse when bcd updates
//   an    : digit anodes, active-low, an[0] is the units digit
//   seg   : segments {g,f,e,d,c,b,a}, active-low
//   dp    : decimal point, active-low, always off
// Modports: master drives value/load (generator side), slave is the display stage.
interface fib_bcd_display_if;
    logic [15:0] value;
    logic        load;
    logic [19:0] bcd;
    logic        busy;
    logic        done;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output value, load,
        input  bcd, busy, done, an, seg, dp
    );

    modport slave (
        input  value, load,
        output bcd, busy, done, an, seg, dp
    );
endinterface

// File: rtl/fib_bcd_display.sv
// Purpose: captures a 16-bit binary sample, converts it to five BCD digits
//          with a sequential double-dabble engine (16 shift cycles), and
//          scans the digits onto an 8-digit active-low seven-segment display
//          with leading-zero blanking.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : fib_bcd_display_if.slave (value/load in; bcd/busy/done/an/seg/dp out)
// Parameters:
//   SCAN_DIV : clock cycles each digit stays lit (>= 2)
module fib_bcd_display #(
    parameter int SCAN_DIV = 100000
) (
    input  logic               clk,
    input  logic               rst,
    fib_bcd_display_if.slave   bus
);

    localparam int PRE_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            r_state;
    state_t            w_stateNext;
    logic [15:0]       r_shift;
    logic [19:0]       r_scratch;
    logic [4:0]        r_count;
    logic [19:0]       r_bcd;
    logic              r_busy;
    logic              r_done;
    logic [PRE_W-1:0]  r_prescale;
    logic [2:0]        r_idx;

    logic              w_capture;
    logic              w_lastShift;
    logic [19:0]       w_adj;
    logic [19:0]       w_scratchNext;
    logic [3:0]        w_digit;
    logic              w_blank;
    logic [7:0]        w_an;
    logic [6:0]        w_seg;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_stateNext;
    end

    // Next-state logic: load is only honoured in IDLE, so loads during SHIFT are dropped
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (bus.load) w_stateNext = SHIFT;
            SHIFT:   if (r_count == 5'd15) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // FSM strobes for the datapath
    always_comb begin
        w_capture   = (r_state == IDLE) && bus.load;
        w_lastShift = (r_state == SHIFT) && (r_count == 5'd15);
    end

    // Add-3 correction per nibble; a corrected nibble tops out at 12, so no carry leaves it
    always_comb begin
        w_adj = r_scratch;
        for (int n = 0; n < 5; n++) begin
            if (r_scratch[4*n +: 4] >= 4'd5)
                w_adj[4*n +: 4] = r_scratch[4*n +: 4] + 4'd3;
        end
        w_scratchNext = {w_adj[18:0], r_shift[15]};
    end

    // Converter datapath; bcd only changes on the final shift so the display never sees partial values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_scratch <= '0;
            r_count   <= '0;
            r_bcd     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_lastShift;
            if (w_capture) begin
                r_shift   <= bus.value;
                r_scratch <= '0;
                r_count   <= '0;
                r_busy    <= 1'b1;
            end else if (r_state == SHIFT) begin
                r_shift   <= {r_shift[14:0], 1'b0};
                r_scratch <= w_scratchNext;
                r_count   <= r_count + 5'd1;
                if (w_lastShift) begin
                    r_bcd  <= w_scratchNext;
                    r_busy <= 1'b0;
                end
            end
        end
    end

    // Free-running scan prescaler and digit index, independent of the converter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prescale <= '0;
            r_idx      <= '0;
        end else if (r_prescale == PRE_W'(SCAN_DIV - 1)) begin
            r_prescale <= '0;
            r_idx      <= (r_idx == 3'd4) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_prescale <= r_prescale + 1'b1;
        end
    end

    // Digit select with leading-zero blanking (digit 0 always shown)
    always_comb begin
        w_digit = r_bcd[3:0];
        w_blank = 1'b0;
        case (r_idx)
            3'd1: begin w_digit = r_bcd[7:4];   w_blank = (r_bcd[19:4]  == 16'd0); end
            3'd2: begin w_digit = r_bcd[11:8];  w_blank = (r_bcd[19:8]  == 12'd0); end
            3'd3: begin w_digit = r_bcd[15:12]; w_blank = (r_bcd[19:12] == 8'd0);  end
            3'd4: begin w_digit = r_bcd[19:16]; w_blank = (r_bcd[19:16] == 4'd0);  end
            default: begin w_digit = r_bcd[3:0]; w_blank = 1'b0; end
        endcase
    end

    // Anode and segment decode
    always_comb begin
        w_an        = 8'hFF;
        w_an[r_idx] = 1'b0;
        case (w_digit)
            4'd0:    w_seg = 7'b1000000;
            4'd1:    w_seg = 7'b1111001;
            4'd2:    w_seg = 7'b0100100;
            4'd3:    w_seg = 7'b0110000;
            4'd4:    w_seg = 7'b0011001;
            4'd5:    w_seg = 7'b0010010;
            4'd6:    w_seg = 7'b0000010;
            4'd7:    w_seg = 7'b1111000;
            4'd8:    w_seg = 7'b0000000;
            4'd9:    w_seg = 7'b0010000;
            default: w_seg = 7'b1111111;
        endcase
        if (w_blank) w_seg = 7'b1111111;
    end

    assign bus.bcd  = r_bcd;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.an   = w_an;
    assign bus.seg  = w_seg;
    assign bus.dp   = 1'b1;

endmodule

// File: tb/tb_fib_bcd_display.sv
// Purpose: directed self-checking bench for fib_bcd_display with SCAN_DIV=4.
//          Inputs are driven and outputs sampled on the falling clock edge.
module tb_fib_bcd_display;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fib_bcd_display_if bus();

    fib_bcd_display #(.SCAN_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports each mismatch
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Load one value and check busy window, done latency and final bcd
    task automatic applyStimulus(input logic [15:0] v, input logic [19:0] exp, input string tag);
        int busyCycles;
        int lat;
        bus.value = v;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
        busyCycles = bus.busy ? 1 : 0;
        lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if (bus.done) lat = k;
            else if (bus.busy) busyCycles++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'd16);
        checkOutput({tag, "_busyCycles"}, 32'(busyCycles), 32'd16);
        checkOutput({tag, "_busyAtDone"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, "_bcd"}, 32'(bus.bcd), 32'(exp));
        @(negedge clk);
        checkOutput({tag, "_donePulse"}, 32'(bus.done), 32'd0);
    endtask

    // Align to digit 0 and check anode/segment pattern for all five digits
    task automatic checkDigits(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3, input logic [6:0] s4);
        logic [6:0] segs [5];
        logic [7:0] anExp;
        bit found;
        segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3; segs[4] = s4;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (bus.an == 8'b11111110) found = 1;
        end
        checkOutput({tag, "_alignDigit0"}, 32'(found), 32'd1);
        for (int d = 0; d < 5; d++) begin
            anExp = 8'hFF;
            anExp[d] = 1'b0;
            checkOutput($sformatf("%s_an%0d", tag, d), 32'(bus.an), 32'(anExp));
            checkOutput($sformatf("%s_seg%0d", tag, d), 32'(bus.seg), 32'(segs[d]));
            repeat (4) @(negedge clk);
        end
    endtask

    initial begin
        int doneCnt;
        int doneAt;
        int doneAt2;
        logic [19:0] bcdFirst;
        logic [7:0] anExp;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.value = 16'd0;
        bus.load  = 1'b0;

        // Reset state and blank scan of a zero result
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_bcd", 32'(bus.bcd), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_dp", 32'(bus.dp), 32'd1);
        checkOutput("rst_an", 32'(bus.an), 32'h0FE);
        checkOutput("rst_seg", 32'(bus.seg), 32'b1000000);
        for (int d = 1; d <= 5; d++) begin
            repeat (4) @(negedge clk);
            anExp = 8'hFF;
            anExp[d % 5] = 1'b0;
            checkOutput($sformatf("scan_an%0d", d % 5), 32'(bus.an), 32'(anExp));
            checkOutput($sformatf("scan_seg%0d", d % 5), 32'(bus.seg),
                        (d == 5) ? 32'b1000000 : 32'b1111111);
        end

        // Maximum value and digit patterns
        applyStimulus(16'hFFFF, 20'h65535, "max");
        applyStimulus(16'd46368, 20'h46368, "fib46368");
        checkDigits("fib46368", 7'b0000000, 7'b0000010, 7'b0110000, 7'b0000010, 7'b0011001);
        applyStimulus(16'd7, 20'h00007, "seven");
        checkDigits("seven", 7'b1111000, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111);
        applyStimulus(16'd1000, 20'h01000, "thousand");
        checkDigits("thousand", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1111001, 7'b1111111);

        // Loads during SHIFT are dropped; a load in the done cycle is accepted
        bus.value = 16'd1597;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        doneCnt = 0; doneAt = 0; doneAt2 = 0; bcdFirst = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done) begin
                doneCnt++;
                if (doneAt == 0) begin doneAt = k; bcdFirst = bus.bcd; end
                else doneAt2 = k;
            end
            bus.load = 1'b0;
            if (k == 2 || k == 8 || k == 16) begin
                bus.value = 16'd5;
                bus.load  = 1'b1;
            end
        end
        checkOutput("ignore_firstDoneAt", 32'(doneAt), 32'd16);
        checkOutput("ignore_firstBcd", 32'(bcdFirst), 32'h01597);
        checkOutput("ignore_doneCount", 32'(doneCnt), 32'd2);
        checkOutput("ignore_secondDoneAt", 32'(doneAt2), 32'd33);
        checkOutput("ignore_secondBcd", 32'(bus.bcd), 32'h00005);

        // Reset mid-conversion aborts and clears bcd
        applyStimulus(16'd1597, 20'h01597, "pre_reset");
        bus.value = 16'd987;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_bcd", 32'(bus.bcd), 32'd0);
        checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        doneCnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.done) doneCnt++;
        end
        checkOutput("midrst_noDone", 32'(doneCnt), 32'd0);
        checkOutput("midrst_bcdHeld", 32'(bus.bcd), 32'd0);
        applyStimulus(16'd987, 20'h00987, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
